// File: rtl/ahb_arb_pkg.sv
// ahb_arb_pkg: AHB transfer/burst encodings, arbiter states and burst length helper.
package ahb_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, NONSEQ, SEQ} htrans_e;

    typedef enum logic [2:0] {SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16} hburst_e;

    typedef enum logic [2:0] {PARK, OWNED, BURST, LOCKED, LOCK_TAIL} arb_state_e;

    function automatic logic [3:0] burst_beats(hburst_e b);
        return (b == WRAP4  || b == INCR4)  ? 4'd3 :
               (b == WRAP8  || b == INCR8)  ? 4'd7 :
               (b == WRAP16 || b == INCR16) ? 4'd15 : 4'd0;
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// ahb_rr_picker: combinational one-hot picker, rotating from base+1 or fixed lowest-index.
module ahb_rr_picker #(
    parameter int N = 4,
    parameter int ROUND_ROBIN = 1,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] base,
    output logic [N-1:0] gnt,
    output logic         valid
);

    logic [W-1:0] k;

    always_comb begin
        gnt = '0;
        k   = '0;
        for (int i = 0; i < N; i++) begin
            k = (ROUND_ROBIN != 0) ? W'((int'(base) + i + 1) % N) : W'(i);
            if (req[k] && gnt == '0) gnt[k] = 1'b1;
        end
    end

    assign valid = |req;

endmodule

// File: rtl/ahb_param_arbiter.sv
// ahb_param_arbiter: AHB arbiter with default-master parking, burst and lock protection.
module ahb_param_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int ROUND_ROBIN = 1,
    localparam int MW = $clog2(NUM_MASTERS)
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MW-1:0]          HMASTER,
    output logic                   HMASTLOCK
);

    localparam logic [NUM_MASTERS-1:0] DEF_OH = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

    arb_state_e state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [MW-1:0] ptr, gidx, widx;
    logic [NUM_MASTERS-1:0] pick, win_oh;
    logic any_req, arb_ok;

    ahb_rr_picker #(.N(NUM_MASTERS), .ROUND_ROBIN(ROUND_ROBIN)) u_pick (
        .req  (HBUSREQ),
        .base (ptr),
        .gnt  (pick),
        .valid(any_req)
    );

    assign win_oh = any_req ? pick : DEF_OH;

    always_comb begin
        gidx = '0;
        widx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (HGRANT[i]) gidx = MW'(i);
            if (win_oh[i]) widx = MW'(i);
        end
    end

    // A NONSEQ opening a defined burst loads a nonzero count, so it never arbitrates
    always_comb begin
        cnt_n = HTRANS == NONSEQ ? burst_beats(hburst_e'(HBURST)) :
                (HTRANS == SEQ && cnt != 4'd0) ? cnt - 4'd1 : cnt;
        arb_ok = HREADY && state != LOCKED && state != LOCK_TAIL && cnt_n == 4'd0;
        state_n = state;
        if (HREADY)
            state_n = state == LOCKED    ? (HLOCK[gidx] ? LOCKED : LOCK_TAIL) :
                      state == LOCK_TAIL ? OWNED :
                      !arb_ok            ? BURST :
                      !any_req           ? PARK :
                      HLOCK[widx]        ? LOCKED : OWNED;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= PARK;
            cnt       <= '0;
            ptr       <= MW'(DEFAULT_MASTER);
            HGRANT    <= DEF_OH;
            HMASTER   <= MW'(DEFAULT_MASTER);
            HMASTLOCK <= 1'b0;
        end else if (HREADY) begin
            state     <= state_n;
            cnt       <= cnt_n;
            HMASTER   <= gidx;
            HMASTLOCK <= HLOCK[gidx];
            if (arb_ok) begin
                HGRANT <= win_oh;
                if (any_req) ptr <= widx;
            end
        end
    end

endmodule

// File: tb/tb_ahb_param_arbiter.sv
// tb_ahb_param_arbiter: directed checks of parking, rotation, bursts, wait states and locks.
module tb_ahb_param_arbiter;
    import ahb_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] req, req_fx, lock;
    logic [1:0] trans;
    logic [2:0] burst;
    logic ready;
    logic [3:0] grant, grant_fx;
    logic [1:0] master, master_fx;
    logic mastlock, mastlock_fx;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ahb_param_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0), .ROUND_ROBIN(1)) dut (
        .HCLK(clk), .HRESET(rst), .HBUSREQ(req), .HLOCK(lock), .HTRANS(trans),
        .HBURST(burst), .HREADY(ready), .HGRANT(grant), .HMASTER(master), .HMASTLOCK(mastlock)
    );

    ahb_param_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0), .ROUND_ROBIN(0)) dut_fx (
        .HCLK(clk), .HRESET(rst), .HBUSREQ(req_fx), .HLOCK(lock), .HTRANS(trans),
        .HBURST(burst), .HREADY(ready), .HGRANT(grant_fx), .HMASTER(master_fx), .HMASTLOCK(mastlock_fx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] rr_exp [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        logic [1:0] rr_mst [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rst = 1'b1; req = '0; req_fx = '0; lock = '0;
        trans = IDLE; burst = SINGLE; ready = 1'b1;
        cyc(2);
        rst = 1'b0;
        check("reset_grant", 32'(grant), 32'h1);
        check("reset_master", 32'(master), 32'h0);
        check("reset_mastlock", 32'(mastlock), 32'h0);
        cyc(10);
        check("park_grant", 32'(grant), 32'h1);
        check("park_master", 32'(master), 32'h0);

        req = 4'hF; req_fx = 4'hF; trans = NONSEQ; burst = SINGLE;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check($sformatf("rr_grant%0d", i), 32'(grant), 32'(rr_exp[i]));
            check($sformatf("rr_master%0d", i), 32'(master), 32'(rr_mst[i]));
            check($sformatf("fx_grant%0d", i), 32'(grant_fx), 32'h1);
        end
        req = '0; req_fx = '0; trans = IDLE;
        cyc(2);
        check("idle_park", 32'(grant), 32'h1);

        req = 4'b0100; req_fx = 4'b0100;
        cyc(1);
        check("m2_grant", 32'(grant), 32'h4);
        check("m2_grant_fx", 32'(grant_fx), 32'h4);
        cyc(1);
        check("m2_master", 32'(master), 32'h2);
        req = 4'b0110; req_fx = 4'b0101; trans = NONSEQ; burst = INCR8;
        cyc(1);
        check("burst_nonseq", 32'(grant), 32'h4);
        check("burst_nonseq_fx", 32'(grant_fx), 32'h4);
        trans = SEQ;
        for (int i = 1; i <= 7; i++) begin
            cyc(1);
            check($sformatf("burst_seq%0d", i), 32'(grant), i == 7 ? 32'h2 : 32'h4);
            check($sformatf("burst_seq%0d_fx", i), 32'(grant_fx), i == 7 ? 32'h1 : 32'h4);
        end
        req = '0; req_fx = '0; trans = IDLE; burst = SINGLE;
        cyc(2);
        check("burst_park", 32'(grant), 32'h1);

        req = 4'b0010; req_fx = 4'b0010;
        cyc(2);
        check("ws_owner", 32'(grant), 32'h2);
        check("ws_owner_master", 32'(master), 32'h1);
        req = 4'b1010; req_fx = 4'b1010; trans = NONSEQ; burst = INCR4;
        cyc(1);
        trans = SEQ;
        cyc(1);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check($sformatf("ws_grant%0d", i), 32'(grant), 32'h2);
            check($sformatf("ws_master%0d", i), 32'(master), 32'h1);
        end
        ready = 1'b1;
        cyc(1);
        check("ws_resume", 32'(grant), 32'h2);
        cyc(1);
        check("ws_handover", 32'(grant), 32'h8);
        req = '0; req_fx = '0; trans = IDLE; burst = SINGLE;
        cyc(2);
        check("ws_park", 32'(grant), 32'h1);

        req = 4'b0010; req_fx = 4'b0010; lock = 4'b0010; trans = NONSEQ;
        cyc(1);
        check("lock_grant", 32'(grant), 32'h2);
        req = 4'b0111; req_fx = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check($sformatf("lock_hold%0d", i), 32'(grant), 32'h2);
            check($sformatf("lock_mastlock%0d", i), 32'(mastlock), 32'h1);
            check($sformatf("lock_master%0d", i), 32'(master), 32'h1);
        end
        lock = '0;
        cyc(1);
        check("lock_fall", 32'(grant), 32'h2);
        check("lock_fall_mastlock", 32'(mastlock), 32'h0);
        cyc(1);
        check("lock_tail", 32'(grant), 32'h2);
        cyc(1);
        check("lock_release", 32'(grant), 32'h4);

        req = 4'b0010; req_fx = 4'b0010; lock = 4'b0010;
        cyc(1);
        check("relock_grant", 32'(grant), 32'h2);
        cyc(1);
        check("relock_mastlock", 32'(mastlock), 32'h1);
        rst = 1'b1;
        cyc(1);
        check("rst_lock_grant", 32'(grant), 32'h1);
        check("rst_lock_master", 32'(master), 32'h0);
        check("rst_lock_mastlock", 32'(mastlock), 32'h0);
        rst = 1'b0; req = '0; req_fx = '0; lock = '0; trans = IDLE;
        cyc(1);
        check("rst_lock_park", 32'(grant), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
